isr_prefetch_queue: RTL

ISR_PREFETCH_QUEUE -- requirements
Module: isr_prefetch_queue

---
 rtl/isr_pkg.sv | 11 +
 rtl/isr_pfq_mem.sv | 24 ++
 rtl/isr_prefetch_queue.sv | 89 ++++++++
 3 files changed

// File: rtl/isr_pkg.sv
// rtl/isr_pkg.sv - shared defaults and word type for the instruction prefetch queue
package isr_pkg;

  localparam int ISR_WIDTH_DEF = 16;
  localparam int ISR_DEPTH_DEF = 4;

  typedef logic [ISR_WIDTH_DEF-1:0] isr_word_t;

  localparam isr_word_t ISR_NOP = 16'h0000;

endpackage

// File: rtl/isr_pfq_mem.sv
// rtl/isr_pfq_mem.sv - DEPTH x WIDTH register array, one write port, one async read port
module isr_pfq_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are deliberately not reset; count/pointers make stale words unreachable.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/isr_prefetch_queue.sv
// rtl/isr_prefetch_queue.sv - instruction prefetch FIFO feeding the decoder; ISR_PFQ_BYPASS_EN enables empty-queue bypass
module isr_prefetch_queue
  import isr_pkg::*;
#(
  parameter int WIDTH = ISR_WIDTH_DEF,
  parameter int DEPTH = ISR_DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic                     MIS,
  input  logic [WIDTH-1:0]         M_BUS,
  input  logic                     POP,
  input  logic                     FLUSH,
  output logic [WIDTH-1:0]         ISR,
  output logic                     ISR_VALID,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf;
  logic [WIDTH-1:0] hold, head;
  logic             queued, pop_ok, push_ok, store, bypass, bypass_pop;

  assign queued  = (count != '0);
  assign FULL    = (count == CW'(DEPTH));
  assign pop_ok  = POP && queued;
  assign push_ok = MIS && (!FULL || pop_ok);

`ifdef ISR_PFQ_BYPASS_EN
  assign bypass = !queued && MIS && !FLUSH;
`else
  assign bypass = 1'b0;
`endif
  // A bypassed word consumed in the same cycle never touches the array.
  assign bypass_pop = bypass && POP;
  assign store      = push_ok && !bypass_pop;

  isr_pfq_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (store && !FLUSH),
    .waddr (wr_ptr),
    .wdata (M_BUS),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      hold   <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      if (queued) hold <= head;
    end else begin
      if (store) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold   <= head;
      end else if (bypass_pop) begin
        hold <= M_BUS;
      end
      count <= count + CW'(store) - CW'(pop_ok);
      if (MIS && !push_ok) ovf <= 1'b1;
    end
  end

  // Hold register keeps the last dequeued word on ISR while the queue is empty.
  assign ISR       = bypass ? M_BUS : (queued ? head : hold);
  assign ISR_VALID = queued || bypass;
  assign COUNT     = count;
  assign OVF       = ovf;

endmodule
